line_buffer_ctrl: RTL
=====================

# line_buffer_ctrl

Controller for the four-line buffering stage that produces the 3x3 filter window. It sits between the pixel source and four line buffers. It steers each incoming pixel into the line buffer currently being filled and tracks how many pixels are stored. Once three full lines are present, it drives read enables to three buffers and assembles their 24-bit prefetch outputs into a 72-bit window for the downstream convolution stage.

## Interface
- IMAGE_WIDTH, 512: pixels per line; also the depth of each line buffer.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_pixel_data  in  8  incoming pixel.
- i_pixel_valid  in  1  i_pixel_data is valid this cycle.
- o_lb_data  out  8  write data to all line buffers; equals i_pixel_data.
- o_lb_wr_valid  out  4  one-hot write strobe, bit n drives line buffer n's data-valid input.
- o_lb_rd_en  out  4  read enables, bit n drives line buffer n's read enable.
- i_lb0_data..i_lb3_data  in  24 each  prefetch output of line buffer 0..3: {p[rd], p[rd+1], p[rd+2]}.
- o_window  out  72  3x3 window: {top line 24b, middle 24b, bottom 24b}.
- o_window_valid  out  1  o_window is valid this cycle.
- o_line_done_intr  out  1  one-cycle pulse after an output line completes.
- o_overflow  out  1  sticky flag; a pixel was dropped because storage was full.

## Operation
- Write side:
  - wr_sel (2b) selects the buffer being filled; wr_cnt counts 0..IMAGE_WIDTH-1.
  - o_lb_wr_valid = i_pixel_valid ? (1 << wr_sel) : 0.
  - On an accepted write, wr_cnt increments. At IMAGE_WIDTH-1 it wraps to 0 and wr_sel increments mod 4.
- Occupancy:
  - total_cnt ranges 0..4*IMAGE_WIDTH, width clog2(4*IMAGE_WIDTH)+1.
  - +1 per accepted write; -1 per read cycle; unchanged when both occur in the same cycle.
- Full:
  - When total_cnt == 4*IMAGE_WIDTH and there is no read that cycle, i_pixel_valid is dropped.
  - A dropped pixel produces no strobe and no counter change, and sets o_overflow. o_overflow clears only on rst.
- FSM, two states:
  - IDLE -> READ when total_cnt >= 3*IMAGE_WIDTH.
  - READ -> IDLE when rd_cnt == IMAGE_WIDTH-1, i.e. on the last read.
  - READ always lasts exactly IMAGE_WIDTH cycles, and at least one IDLE cycle separates consecutive lines.
- Read side (READ state):
  - rd_sel (2b) is the top line. rd_en is asserted each cycle for buffers rd_sel, rd_sel+1 and rd_sel+2, all mod 4.
  - rd_cnt counts 0..IMAGE_WIDTH-1. On the last read, rd_cnt goes to 0 and rd_sel increments mod 4.
- Window:
  - o_window = {i_lb[rd_sel], i_lb[rd_sel+1], i_lb[rd_sel+2]}, combinational from the inputs; the oldest line is in the MSBs.
  - o_window_valid = (state == READ). In IDLE, o_window is don't-care.
- Interrupt: o_line_done_intr is registered and is high for the one cycle following the last read of a line.
- Edge handling: the window does not handle edges. Right-edge replication is the line buffer's job; top/bottom handling belongs downstream.

## Timing
- Reset (rst high at a rising edge):
  - wr_sel, wr_cnt, rd_sel, rd_cnt and total_cnt go to 0; state goes to IDLE.
  - o_line_done_intr, o_overflow, o_window_valid and o_lb_rd_en go to 0.
  - While rst is high, o_lb_wr_valid is forced to 0.
  - Reset mid-line discards all stored data; the next pixel lands in buffer 0 at index 0.
- Start of read: if the write that brings total_cnt to 3*IMAGE_WIDTH is accepted at edge k, the FSM enters READ at edge k+1. o_window_valid and o_lb_rd_en are high for cycles k+1 .. k+IMAGE_WIDTH.
- Window update: the line buffer pointers advance at each rd_en edge, so the window in cycle k+1+j covers column j.
- Interrupt timing: o_line_done_intr is high for exactly the cycle k+IMAGE_WIDTH+1. State is IDLE in that cycle; the earliest next READ is at k+IMAGE_WIDTH+2.
- Streaming: writes may continue during READ at up to one per cycle with no stall.
- Backpressure: upstream must stop before total_cnt reaches 4*IMAGE_WIDTH; otherwise o_overflow is set.

## Test plan
- Reset, then write 3*W-1 pixels (W = IMAGE_WIDTH) -> o_window_valid stays 0, o_lb_wr_valid cycles 0001 then 0010 then 0100, no interrupt.
- Write 3 lines with pixel value equal to the line number (0, 1, 2), then stop -> one cycle after the last write, o_lb_rd_en = 0111 for W cycles. o_window = {0x000000, 0x010101, 0x020202} throughout. o_line_done_intr pulses exactly once, in the cycle after the last read.
- Continuous stream of 5 lines, values = line number -> second window = {01.., 02.., 03..} with rd_en 1110; third window = {02.., 03.., 04..} with rd_en 1101 (wr_sel has wrapped to buffer 0); total_cnt is never changed by simultaneous read/write cycles.
- Assert rst for one cycle in the middle of the second READ -> next cycle all outputs are 0 and state is IDLE. Refilling 3 lines restarts from buffer 0 with rd_en 0111.
- Continuous pixels for 2*W+4 lines without gaps -> total_cnt grows by 1 per line. o_overflow rises in the cycle after the first dropped pixel, with no o_lb_wr_valid strobe in that cycle, and stays 1 until rst.

Source files
------------

// File: rtl/line_buffer_ctrl_if.sv
`default_nettype none
// ==========================================================================
// line_buffer_ctrl_if - pixel, line-buffer and window signals of the controller
// Revision 1.0
// ==========================================================================
interface line_buffer_ctrl_if;
  logic [7:0]  i_pixel_data;
  logic        i_pixel_valid;
  logic [7:0]  o_lb_data;
  logic [3:0]  o_lb_wr_valid;
  logic [3:0]  o_lb_rd_en;
  logic [23:0] i_lb0_data;
  logic [23:0] i_lb1_data;
  logic [23:0] i_lb2_data;
  logic [23:0] i_lb3_data;
  logic [71:0] o_window;
  logic        o_window_valid;
  logic        o_line_done_intr;
  logic        o_overflow;

  // controller side
  modport master (
    input  i_pixel_data, i_pixel_valid,
    input  i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
    output o_lb_data, o_lb_wr_valid, o_lb_rd_en,
    output o_window, o_window_valid, o_line_done_intr, o_overflow
  );

  // pixel source / line buffers / downstream side
  modport slave (
    output i_pixel_data, i_pixel_valid,
    output i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
    input  o_lb_data, o_lb_wr_valid, o_lb_rd_en,
    input  o_window, o_window_valid, o_line_done_intr, o_overflow
  );
endinterface
`default_nettype wire

// File: rtl/line_buffer_ctrl.sv
`default_nettype none
// ==========================================================================
// line_buffer_ctrl - steers pixels into four line buffers, emits a 3x3 window
// Revision 1.0
// ==========================================================================
module line_buffer_ctrl #(
  parameter int IMAGE_WIDTH = 512
) (
  input  wire logic        clk,
  input  wire logic        rst,
  line_buffer_ctrl_if.master bus
);

  localparam int CNT_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int TOT_W = $clog2(4 * IMAGE_WIDTH) + 1;

  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(IMAGE_WIDTH - 1);
  localparam logic [TOT_W-1:0] C_FULL_LVL  = TOT_W'(4 * IMAGE_WIDTH);
  localparam logic [TOT_W-1:0] C_START_LVL = TOT_W'(3 * IMAGE_WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       wr_sel_q, wr_sel_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [1:0]       rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [TOT_W-1:0] total_cnt_q, total_cnt_d;
  logic             line_done_q, line_done_d;
  logic             overflow_q, overflow_d;

  logic rd_active;
  logic full;
  logic wr_drop;
  logic wr_accept;
  logic last_rd;

  assign rd_active = (state_q == S_READ);
  assign full      = (total_cnt_q == C_FULL_LVL);
  // a read in the same cycle frees a slot, so a full store still accepts then
  assign wr_drop   = bus.i_pixel_valid && full && !rd_active;
  assign wr_accept = bus.i_pixel_valid && !rst && !wr_drop;
  assign last_rd   = rd_active && (rd_cnt_q == C_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_sel_q    <= 2'd0;
      wr_cnt_q    <= '0;
      rd_sel_q    <= 2'd0;
      rd_cnt_q    <= '0;
      total_cnt_q <= '0;
      line_done_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_sel_q    <= wr_sel_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_sel_q    <= rd_sel_d;
      rd_cnt_q    <= rd_cnt_d;
      total_cnt_q <= total_cnt_d;
      line_done_q <= line_done_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_sel_d    = wr_sel_q;
    wr_cnt_d    = wr_cnt_q;
    rd_sel_d    = rd_sel_q;
    rd_cnt_d    = rd_cnt_q;
    total_cnt_d = total_cnt_q;
    line_done_d = last_rd;
    overflow_d  = overflow_q | wr_drop;

    case (state_q)
      S_IDLE:  if (total_cnt_q >= C_START_LVL) state_d = S_READ;
      S_READ:  if (last_rd) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (wr_accept) begin
      if (wr_cnt_q == C_LAST) begin
        wr_cnt_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    if (rd_active) begin
      if (last_rd) begin
        rd_cnt_d = '0;
        rd_sel_d = rd_sel_q + 2'd1;
      end else begin
        rd_cnt_d = rd_cnt_q + CNT_W'(1);
      end
    end

    case ({wr_accept, rd_active})
      2'b10:   total_cnt_d = total_cnt_q + TOT_W'(1);
      2'b01:   total_cnt_d = total_cnt_q - TOT_W'(1);
      default: total_cnt_d = total_cnt_q;
    endcase
  end

  logic [23:0] lb_data [4];
  logic [1:0]  mid_sel;
  logic [1:0]  bot_sel;

  assign lb_data[0] = bus.i_lb0_data;
  assign lb_data[1] = bus.i_lb1_data;
  assign lb_data[2] = bus.i_lb2_data;
  assign lb_data[3] = bus.i_lb3_data;
  assign mid_sel    = rd_sel_q + 2'd1;
  assign bot_sel    = rd_sel_q + 2'd2;

  always_comb begin
    bus.o_lb_data        = bus.i_pixel_data;
    bus.o_lb_wr_valid    = 4'b0000;
    bus.o_lb_rd_en       = 4'b0000;
    bus.o_window         = {lb_data[rd_sel_q], lb_data[mid_sel], lb_data[bot_sel]};
    bus.o_window_valid   = rd_active;
    bus.o_line_done_intr = line_done_q;
    bus.o_overflow       = overflow_q;
    if (wr_accept) begin
      bus.o_lb_wr_valid = 4'b0001 << wr_sel_q;
    end
    // the only buffer not read is the one just behind the top line
    if (rd_active) begin
      bus.o_lb_rd_en = ~(4'b0001 << (rd_sel_q + 2'd3));
    end
  end

endmodule
`default_nettype wire
